cp0_regs: RTL



---
 rtl/cp0_regs_if.sv | 37 +++
 rtl/cp0_regs.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cp0_regs_if.sv
// Bus between the writeback/exception stage and the CP0 register block:
// mfc0/mtc0 access, exception/ERET commit, interrupt lines and status back.
interface cp0_regs_if #(
    parameter int HW_INTR = 6
) ();
    logic [4:0]         rd_addr;
    logic [31:0]        rd_data;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               exc_valid;
    logic [4:0]         exc_code;
    logic               exc_bd;
    logic [31:0]        exc_pc;
    logic               exc_badva_we;
    logic [31:0]        exc_badva;
    logic               eret;
    logic [HW_INTR-1:0] hw_intr;
    logic [7:0]         intr_vect;
    logic               intr_pending;
    logic [31:0]        epc;
    logic               status_exl;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output exc_valid, exc_code, exc_bd, exc_pc, exc_badva_we, exc_badva,
        output eret, hw_intr,
        input  rd_data, intr_vect, intr_pending, epc, status_exl
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  exc_valid, exc_code, exc_bd, exc_pc, exc_badva_we, exc_badva,
        input  eret, hw_intr,
        output rd_data, intr_vect, intr_pending, epc, status_exl
    );
endinterface

// File: rtl/cp0_regs.sv
// MIPS32 CP0 register block: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception/ERET bookkeeping, Count/Compare timer and interrupt masking.
module cp0_regs #(
    parameter int HW_INTR   = 6,  // must match the connected interface
    parameter int COUNT_DIV = 2
) (
    input logic       clk,
    input logic       rst,
    cp0_regs_if.slave bus
);
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]      badvaddr_q;
    logic [31:0]      count_q;
    logic [31:0]      compare_q;
    logic [31:0]      epc_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       im_q;
    logic             exl_q;
    logic             ie_q;
    logic             bd_q;
    logic             ti_q;
    logic [4:0]       exc_code_q;
    logic [5:0]       ip_hw_q;
    logic [1:0]       ip_sw_q;

    // An exception or ERET in the same cycle swallows the mtc0 completely.
    logic mtc0_ok;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic tick;

    assign mtc0_ok    = bus.wr_en & ~bus.exc_valid & ~bus.eret;
    assign wr_count   = mtc0_ok && (bus.wr_addr == ADDR_COUNT);
    assign wr_compare = mtc0_ok && (bus.wr_addr == ADDR_COMPARE);
    assign wr_status  = mtc0_ok && (bus.wr_addr == ADDR_STATUS);
    assign wr_cause   = mtc0_ok && (bus.wr_addr == ADDR_CAUSE);
    assign wr_epc     = mtc0_ok && (bus.wr_addr == ADDR_EPC);
    assign tick       = (div_q == DIV_LAST);

    logic [5:0] hw_ext;
    logic [7:0] ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        hw_ext = '0;
        hw_ext[HW_INTR-1:0] = bus.hw_intr;
    end

    assign ip        = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

    // Count divider, Count and Compare/TI timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses <= so every register sees pre-edge values.
            count_q   <= '0;
            div_q     <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= bus.wr_data;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
                div_q   <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (wr_compare) begin
                compare_q <= bus.wr_data;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    // Hardware interrupt lines are sampled once per cycle into Cause.IP[7:2].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip_hw_q <= '0;
        end else begin
            ip_hw_q <= hw_ext;
        end
    end

    // Exception entry, ERET and mtc0 to Status/Cause/EPC, in that priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
        end else if (bus.exc_valid) begin
            // A nested exception keeps the EPC/BD of the outermost one.
            if (!exl_q) begin
                epc_q <= bus.exc_pc;
                bd_q  <= bus.exc_bd;
            end
            exl_q      <= 1'b1;
            exc_code_q <= bus.exc_code;
            if (bus.exc_badva_we) begin
                badvaddr_q <= bus.exc_badva;
            end
        end else if (bus.eret) begin
            exl_q <= 1'b0;
        end else begin
            if (wr_status) begin
                im_q  <= bus.wr_data[15:8];
                exl_q <= bus.wr_data[1];
                ie_q  <= bus.wr_data[0];
            end
            if (wr_cause) begin
                ip_sw_q <= bus.wr_data[9:8];
            end
            if (wr_epc) begin
                epc_q <= bus.wr_data;
            end
        end
    end

    // mfc0 read has no write bypass: it always shows the registered value.
    logic [31:0] rd_data_c;

    always_comb begin
        rd_data_c = '0;
        case (bus.rd_addr)
            ADDR_BADVADDR: rd_data_c = badvaddr_q;
            ADDR_COUNT:    rd_data_c = count_q;
            ADDR_COMPARE:  rd_data_c = compare_q;
            ADDR_STATUS:   rd_data_c = status_rd;
            ADDR_CAUSE:    rd_data_c = cause_rd;
            ADDR_EPC:      rd_data_c = epc_q;
            default:       rd_data_c = '0;
        endcase
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.intr_vect    = ip & im_q & {8{ie_q & ~exl_q}};
    assign bus.intr_pending = |bus.intr_vect;
    assign bus.epc          = epc_q;
    assign bus.status_exl   = exl_q;

endmodule
